// File: rtl/ula_muldiv_if.sv
// Datapath-side connection to the HI/LO multiply/divide unit: operation
// request, direct HI/LO writes, and status/result readback.
interface ula_muldiv_if;
    logic        start;
    logic [1:0]  OP;
    logic [31:0] In1;
    logic [31:0] In2;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, OP, In1, In2, mt_we, mt_sel, mt_data,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, OP, In1, In2, mt_we, mt_sel, mt_data,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/ula_muldiv.sv
// MIPS HI/LO owner: bit-serial MULT/MULTU/DIV/DIVU on magnitudes, one bit per
// cycle for 32 cycles, followed by a sign-fix cycle that writes HI/LO.
module ula_muldiv (
    input  logic         clk,
    input  logic         reset,
    ula_muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        is_div_q, is_div_d;
    logic        sign_q_q, sign_q_d;
    logic        sign_r_q, sign_r_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        op_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [31:0] rem_sub;
    logic [32:0] sum;
    logic [63:0] prod;

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic s);
        return s ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic s);
        return s ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        op_signed = ~bus.OP[0];
        a_mag     = op_signed ? abs32(bus.In1) : bus.In1;
        b_mag     = op_signed ? abs32(bus.In2) : bus.In2;
        shifted   = {acc_q[63:32], acc_q[31]};
        rem_sub   = shifted[31:0] - opb_q;
        sum       = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        prod      = cond_neg64(acc_q, sign_q_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.OP[1];
                    sign_q_d = op_signed & (bus.In1[31] ^ bus.In2[31]);
                    sign_r_d = op_signed & bus.In1[31];
                    cnt_d    = 5'd0;
                    busy_d   = 1'b1;
                    if (bus.OP[1] && (bus.In2 == 32'd0)) begin
                        // Keep the raw dividend; it becomes HI unchanged.
                        dz_d    = 1'b1;
                        acc_d   = {bus.In1, 32'd0};
                        opb_d   = 32'd0;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = {32'd0, bus.OP[1] ? a_mag : b_mag};
                        opb_d   = bus.OP[1] ? b_mag : a_mag;
                        state_d = S_RUN;
                    end
                end else if (bus.mt_we) begin
                    if (bus.mt_sel) hi_d = bus.mt_data;
                    else            lo_d = bus.mt_data;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                // Divide: acc = {partial remainder, dividend/quotient bits}.
                // Multiply: acc = {running high product, remaining multiplier}.
                if (is_div_q) begin
                    if (shifted >= {1'b0, opb_q}) acc_d = {rem_sub, acc_q[30:0], 1'b1};
                    else                          acc_d = {shifted[31:0], acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {sum, acc_q[31:1]};
                end
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_q) begin
                    hi_d  = acc_q[63:32];
                    lo_d  = 32'hFFFF_FFFF;
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = cond_neg32(acc_q[63:32], sign_r_q);
                    lo_d = cond_neg32(acc_q[31:0], sign_q_q);
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opb_q    <= 32'd0;
            is_div_q <= 1'b0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// Directed bench for ula_muldiv: an arithmetic reference model checked every
// cycle, plus hand-computed literal expectations for each directed case.
module tb_ula_muldiv;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ula_muldiv_if bus();

    ula_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {div_by_zero, HI, LO} from plain arithmetic.
    function automatic logic [64:0] compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] up;
        logic [64:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            OP_MULT: begin
                q = sa * sb;
                res = {1'b0, q[63:32], q[31:0]};
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                res = {1'b0, up};
            end
            default: begin
                if (b == 32'd0) begin
                    res = {1'b1, a, 32'hFFFF_FFFF};
                end else if (op == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {1'b0, r[31:0], q[31:0]};
                end else begin
                    res = {1'b0, a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    logic        m_busy, m_done, m_dbz;
    logic [31:0] m_hi, m_lo;
    logic [64:0] p_res;
    int          m_rem;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_rem  <= 0;
            p_res  <= '0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (m_busy) begin
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_dbz  <= p_res[64];
                    m_hi   <= p_res[63:32];
                    m_lo   <= p_res[31:0];
                end
                m_rem <= m_rem - 1;
            end else if (bus.start) begin
                p_res  <= compute(bus.OP, bus.In1, bus.In2);
                m_busy <= 1'b1;
                m_rem  <= (bus.OP[1] && bus.In2 == 32'd0) ? 1 : 33;
            end else if (bus.mt_we) begin
                if (bus.mt_sel) m_hi <= bus.mt_data;
                else            m_lo <= bus.mt_data;
            end
        end
    end

    always @(negedge clk) begin
        check32("busy", {31'd0, bus.busy}, {31'd0, m_busy});
        check32("done", {31'd0, bus.done}, {31'd0, m_done});
        check32("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, m_dbz});
        check32("HI", bus.HI, m_hi);
        check32("LO", bus.LO, m_lo);
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic wsel, input logic [31:0] wd);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.OP      = op;
        bus.In1     = a;
        bus.In2     = b;
        bus.mt_we   = we;
        bus.mt_sel  = wsel;
        bus.mt_data = wd;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mt_we = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_k);
        int k = 1;
        int bc = 0;
        while (!bus.done && k < 50) begin
            if (bus.busy) bc++;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!bus.done) begin
            n_errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", nm, k);
        end
        check32({nm, "_latency"}, k, exp_k);
        check32({nm, "_busy_cycles"}, bc, exp_k - 1);
    endtask

    task automatic expect_result(input string nm, input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
        check32({nm, "_HI"}, bus.HI, hi);
        check32({nm, "_LO"}, bus.LO, lo);
        check32({nm, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, dbz});
    endtask

    initial begin
        int nd;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.OP      = 2'b00;
        bus.In1     = 32'd0;
        bus.In2     = 32'd0;
        bus.mt_we   = 1'b0;
        bus.mt_sel  = 1'b0;
        bus.mt_data = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check32("reset_HI", bus.HI, 32'd0);
        check32("reset_LO", bus.LO, 32'd0);
        check32("reset_busy", {31'd0, bus.busy}, 32'd0);
        check32("reset_done", {31'd0, bus.done}, 32'd0);

        // Direct LO write in IDLE
        @(negedge clk);
        bus.mt_we = 1'b1; bus.mt_sel = 1'b0; bus.mt_data = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.mt_we = 1'b0;
        check32("mtlo_LO", bus.LO, 32'hA5A5_A5A5);
        check32("mtlo_HI", bus.HI, 32'd0);
        check32("mtlo_done", {31'd0, bus.done}, 32'd0);

        // Reset in the middle of RUN, sampled at E10
        issue(OP_MULTU, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check32("rst_run_busy", {31'd0, bus.busy}, 32'd0);
        check32("rst_run_done", {31'd0, bus.done}, 32'd0);
        check32("rst_run_HI", bus.HI, 32'd0);
        check32("rst_run_LO", bus.LO, 32'd0);
        reset = 1'b0;
        issue(OP_MULTU, 32'd5, 32'd7, 1'b0, 1'b0, 32'd0);
        wait_done("multu_5x7", 34);
        expect_result("multu_5x7", 32'd0, 32'd35, 1'b0);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'd0);
        wait_done("mult_m1x2", 34);
        expect_result("mult_m1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, 32'd0);
        wait_done("multu_maxx2", 34);
        expect_result("multu_maxx2", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);

        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
        wait_done("divu_100_7", 34);
        expect_result("divu_100_7", 32'd2, 32'd14, 1'b0);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
        wait_done("div_m7_2", 34);
        expect_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        wait_done("div_ovf", 34);
        expect_result("div_ovf", 32'd0, 32'h8000_0000, 1'b0);

        issue(OP_DIV, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'd0);
        wait_done("div_zero", 2);
        expect_result("div_zero", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

        issue(OP_DIVU, 32'd9, 32'd3, 1'b0, 1'b0, 32'd0);
        wait_done("divu_9_3", 34);
        expect_result("divu_9_3", 32'd0, 32'd3, 1'b0);

        // Handshake abuse: restart at E5 and MTHI at E7 while busy
        issue(OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.OP = OP_MULTU; bus.In1 = 32'd7; bus.In2 = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.mt_we = 1'b1; bus.mt_sel = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mt_we = 1'b0;
        check32("abuse_HI_kept", bus.HI, 32'd0);
        nd = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check32("abuse_done_count", nd, 32'd1);
        expect_result("abuse_mult_3x4", 32'd0, 32'd12, 1'b0);

        // start and mt_we together: the operation wins
        issue(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b1, 32'h1111_1111);
        check32("start_mt_HI", bus.HI, 32'd0);
        wait_done("start_mt", 34);
        expect_result("start_mt", 32'd0, 32'd42, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
